alu_rs: RTL and testbench

ALU reservation station: a compacting, age-ordered issue queue that sits directly upstream of `alu`. It accepts renamed ALU and branch micro-ops from dispatch and captures operand results broadcast on the CDB. Each cycle it selects the oldest entry whose operands are all available and hands that entry to `alu` as `alu_packet`.

---
 rtl/alu_rs.sv | 147 ++++++++++++++
 tb/tb_alu_rs.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - compacting age-ordered ALU reservation station
package alu_rs_pkg;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              is_renamed;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  typedef struct packed {
    logic             is_valid;
    logic [3:0]       opcode;
    logic [TAG_W-1:0] dest_tag;
    operand_t         src_0_a;
    operand_t         src_0_b;
    operand_t         src_1_a;
    operand_t         src_1_b;
  } instruction_t;

  typedef struct packed {
    logic              is_valid;
    logic [TAG_W-1:0]  dest_tag;
    logic [DATA_W-1:0] result;
  } writeback_packet_t;
endpackage

module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_DEPTH  = 8,
  parameter int CDB_PORTS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              alu_rs_rdy,
  input  logic              alu_rs_we,
  input  instruction_t      alu_rs_entry,
  input  writeback_packet_t cdb_ports [CDB_PORTS],
  input  logic              alu_rdy,
  output instruction_t      alu_packet
);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = $clog2(RS_DEPTH);

  instruction_t        ent     [RS_DEPTH];
  instruction_t        ent_nxt [RS_DEPTH];
  instruction_t        shifted [RS_DEPTH];
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_nxt;
  logic [CNT_W-1:0]    wr_idx;
  logic [RS_DEPTH-1:0] ready;
  logic [RS_DEPTH-1:0] shift_mask;
  logic [IDX_W-1:0]    sel;
  logic                any_ready;
  logic                issue_fire;
  logic                accept;

  // Ports are scanned high to low so the lowest-numbered match is the last write.
  function automatic operand_t wake_src(input operand_t s);
    operand_t r;
    r = s;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (s.is_renamed && cdb_ports[p].is_valid && cdb_ports[p].dest_tag == s.tag) begin
        r.data       = cdb_ports[p].result;
        r.is_renamed = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic instruction_t wake_instr(input instruction_t e);
    instruction_t r;
    r         = e;
    r.src_0_a = wake_src(e.src_0_a);
    r.src_0_b = wake_src(e.src_0_b);
    r.src_1_a = wake_src(e.src_1_a);
    r.src_1_b = wake_src(e.src_1_b);
    return r;
  endfunction

  always_comb begin
    ready      = '0;
    shift_mask = '0;
    sel        = '0;
    any_ready  = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = ent[i].is_valid &&
                 !(ent[i].src_0_a.is_renamed || ent[i].src_0_b.is_renamed ||
                   ent[i].src_1_a.is_renamed || ent[i].src_1_b.is_renamed);
      if (ready[i] && !any_ready) begin
        any_ready = 1'b1;
        sel       = IDX_W'(i);
      end
      // Every entry at or above the selected one moves down on issue.
      shift_mask[i] = any_ready;
    end
  end

  assign issue_fire = alu_rdy && any_ready && !flush;
  assign alu_rs_rdy = (count < CNT_W'(RS_DEPTH));
  assign accept     = alu_rs_we && alu_rs_rdy && !flush;
  assign wr_idx     = count - CNT_W'(issue_fire);

  always_comb begin
    alu_packet = '0;
    if (issue_fire) begin
      alu_packet          = ent[sel];
      alu_packet.is_valid = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH - 1; i++) begin
      shifted[i] = ent[i + 1];
    end
    shifted[RS_DEPTH-1] = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_nxt[i] = (issue_fire && shift_mask[i]) ? shifted[i] : ent[i];
      if (ent_nxt[i].is_valid) begin
        ent_nxt[i] = wake_instr(ent_nxt[i]);
      end
      if (accept && wr_idx == CNT_W'(i)) begin
        ent_nxt[i]          = wake_instr(alu_rs_entry);
        ent_nxt[i].is_valid = 1'b1;
      end
      if (flush) begin
        ent_nxt[i].is_valid = 1'b0;
      end
    end
    count_nxt = flush ? '0 : count + CNT_W'(accept) - CNT_W'(issue_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent[i] <= '0;
      end
      count <= '0;
    end else begin
      ent   <= ent_nxt;
      count <= count_nxt;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - scoreboard bench for alu_rs
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int RS_DEPTH  = 8;
  localparam int CDB_PORTS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              alu_rs_rdy;
  logic              alu_rs_we;
  instruction_t      alu_rs_entry;
  writeback_packet_t cdb_ports [CDB_PORTS];
  logic              alu_rdy;
  instruction_t      alu_packet;

  alu_rs #(.RS_DEPTH(RS_DEPTH), .CDB_PORTS(CDB_PORTS)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alu_rs_rdy   (alu_rs_rdy),
    .alu_rs_we    (alu_rs_we),
    .alu_rs_entry (alu_rs_entry),
    .cdb_ports    (cdb_ports),
    .alu_rdy      (alu_rdy),
    .alu_packet   (alu_packet)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    instruction_t pkt;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic operand_t opnd(input logic ren, input logic [5:0] tag, input logic [31:0] data);
    operand_t r;
    r.is_renamed = ren;
    r.tag        = tag;
    r.data       = data;
    return r;
  endfunction

  function automatic instruction_t mk(input logic [3:0] opc, input logic [5:0] dst,
                                      input operand_t a, input operand_t b);
    instruction_t r;
    r          = '0;
    r.is_valid = 1'b1;
    r.opcode   = opc;
    r.dest_tag = dst;
    r.src_0_a  = a;
    r.src_0_b  = b;
    return r;
  endfunction

  function automatic instruction_t rdy_op(input int n);
    return mk(4'h5, 6'(n), opnd(1'b0, 6'd0, 32'(n * 16 + 1)), opnd(1'b0, 6'd0, 32'(n * 16 + 2)));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic expect_issue(input instruction_t p, input int c);
    exp_t e;
    e.pkt = p;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_rs_we    = 1'b0;
    alu_rs_entry = '0;
    flush        = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++) cdb_ports[p] = '0;
  endtask

  task automatic dispatch(input instruction_t e);
    alu_rs_we    = 1'b1;
    alu_rs_entry = e;
  endtask

  task automatic cdb(input int p, input logic [5:0] tag, input logic [31:0] res);
    cdb_ports[p].is_valid = 1'b1;
    cdb_ports[p].dest_tag = tag;
    cdb_ports[p].result   = res;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (alu_packet.is_valid === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected cyc=%0d got=%h expected=none", cyc, alu_packet);
      end else begin
        e = sb.pop_front();
        if (alu_packet !== e.pkt) begin
          n_err++;
          $display("FAIL issue_data cyc=%0d got=%h expected=%h", cyc, alu_packet, e.pkt);
        end else if (e.cyc >= 0 && cyc != e.cyc) begin
          n_err++;
          $display("FAIL issue_cycle got=%0d expected=%0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    instruction_t e0, e1, x0;
    rst     = 1'b1;
    alu_rdy = 1'b0;
    idle();
    repeat (2) tick();
    check("reset_rdy", 32'(alu_rs_rdy), 32'd1);
    check("reset_pkt_valid", 32'(alu_packet.is_valid), 32'd0);
    rst = 1'b0;
    tick();

    // reset mid-operation with 3 entries held
    for (int i = 1; i <= 3; i++) begin
      dispatch(rdy_op(i));
      tick();
    end
    idle();
    alu_rdy = 1'b1;
    rst     = 1'b1;
    #1;
    check("async_reset_rdy", 32'(alu_rs_rdy), 32'd1);
    check("async_reset_pkt_valid", 32'(alu_packet.is_valid), 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // ready dispatch and age order
    e0 = mk(4'h1, 6'd10, opnd(1'b0, 6'd0, 32'd5), opnd(1'b0, 6'd0, 32'd7));
    dispatch(e0);
    expect_issue(e0, cyc + 1);
    tick();
    idle();
    repeat (2) tick();
    dispatch(rdy_op(11));
    expect_issue(rdy_op(11), cyc + 1);
    tick();
    dispatch(rdy_op(12));
    expect_issue(rdy_op(12), cyc + 1);
    tick();
    idle();
    repeat (2) tick();

    // wakeup one cycle after dispatch
    e0 = mk(4'h2, 6'd11, opnd(1'b1, 6'd3, 32'd0), opnd(1'b0, 6'd0, 32'd2));
    x0 = mk(4'h2, 6'd11, opnd(1'b0, 6'd3, 32'hA), opnd(1'b0, 6'd0, 32'd2));
    dispatch(e0);
    expect_issue(x0, cyc + 2);
    tick();
    idle();
    cdb(1, 6'd3, 32'hA);
    tick();
    idle();
    repeat (2) tick();

    // dispatch bypass
    dispatch(e0);
    cdb(1, 6'd3, 32'hA);
    expect_issue(x0, cyc + 1);
    tick();
    idle();
    repeat (2) tick();

    // both ports match: port 0 wins
    e1         = mk(4'h3, 6'd12, opnd(1'b0, 6'd0, 32'd4), opnd(1'b0, 6'd0, 32'd6));
    e1.src_1_b = opnd(1'b1, 6'd7, 32'd0);
    x0         = e1;
    x0.src_1_b = opnd(1'b0, 6'd7, 32'hB);
    dispatch(e1);
    expect_issue(x0, cyc + 2);
    tick();
    idle();
    cdb(0, 6'd7, 32'hB);
    cdb(1, 6'd7, 32'hC);
    tick();
    idle();
    repeat (2) tick();

    // out-of-order select
    alu_rdy = 1'b0;
    e0 = mk(4'h3, 6'd20, opnd(1'b1, 6'd9, 32'd0), opnd(1'b0, 6'd0, 32'd1));
    e1 = mk(4'h4, 6'd21, opnd(1'b0, 6'd0, 32'd2), opnd(1'b0, 6'd0, 32'd3));
    x0 = mk(4'h3, 6'd20, opnd(1'b0, 6'd9, 32'h99), opnd(1'b0, 6'd0, 32'd1));
    dispatch(e0);
    tick();
    dispatch(e1);
    tick();
    idle();
    alu_rdy = 1'b1;
    expect_issue(e1, cyc);
    tick();
    cdb(0, 6'd9, 32'h99);
    expect_issue(x0, cyc + 1);
    tick();
    idle();
    repeat (2) tick();

    // fill, overflow attempt, then drain
    alu_rdy = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      check("rdy_while_filling", 32'(alu_rs_rdy), 32'd1);
      dispatch(rdy_op(i));
      tick();
    end
    idle();
    check("rdy_full", 32'(alu_rs_rdy), 32'd0);
    dispatch(rdy_op(15));
    tick();
    idle();
    check("rdy_full_after_ignored_write", 32'(alu_rs_rdy), 32'd0);
    alu_rdy = 1'b1;
    for (int i = 0; i < RS_DEPTH; i++) expect_issue(rdy_op(i), cyc + i);
    check("rdy_full_issue_cycle", 32'(alu_rs_rdy), 32'd0);
    tick();
    check("rdy_after_first_issue", 32'(alu_rs_rdy), 32'd1);
    repeat (RS_DEPTH + 2) tick();

    // flush with concurrent write and issue
    alu_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dispatch(rdy_op(i + 1));
      tick();
    end
    idle();
    flush = 1'b1;
    dispatch(rdy_op(14));
    alu_rdy = 1'b1;
    #1;
    check("flush_no_issue", 32'(alu_packet.is_valid), 32'd0);
    tick();
    idle();
    check("rdy_after_flush", 32'(alu_rs_rdy), 32'd1);
    repeat (3) tick();
    alu_rdy = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      check("rdy_refill_after_flush", 32'(alu_rs_rdy), 32'd1);
      dispatch(rdy_op(i + 1));
      tick();
    end
    idle();
    check("rdy_full_after_refill", 32'(alu_rs_rdy), 32'd0);
    flush = 1'b1;
    tick();
    idle();
    check("rdy_after_second_flush", 32'(alu_rs_rdy), 32'd1);
    alu_rdy = 1'b1;
    repeat (3) tick();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
